// File: rtl/fetch_redirect_if.sv
// Fetch-side bus between the instruction-fetch stage and the fetch redirect unit.
// Handshake: if_valid qualifies if_instr/if_pc in the same cycle. There is no
// ready; the consumer takes every word, and downstream hold is a separate stall.
// jumpEnable qualifies jumpAddress. Fetch loads jumpAddress on the next rising edge.
interface fetch_redirect_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] if_instr;
  logic [WIDTH-1:0] if_pc;
  logic             if_valid;
  logic [WIDTH-1:0] jumpAddress;
  logic             jumpEnable;

  // Fetch stage side.
  modport master (
    output if_instr, if_pc, if_valid,
    input  jumpAddress, jumpEnable
  );

  // Redirect unit side.
  modport slave (
    input  if_instr, if_pc, if_valid,
    output jumpAddress, jumpEnable
  );
endinterface

// File: rtl/fetch_redirect_unit.sv
// Fetch redirect unit: IF/ID pipeline register, decode of JMP/BEQZ, and
// squashing of wrong-path words that are already in flight after a redirect.
module fetch_redirect_unit #(
  parameter int EXTRA_SQUASH = 0,
  parameter int WIDTH        = 16
) (
  input  logic              clock,
  input  logic              reset,
  fetch_redirect_if.slave   fetch,
  input  logic              stall,
  input  logic              rs_zero,
  output logic [WIDTH-1:0]  id_instr,
  output logic [WIDTH-1:0]  id_pc,
  output logic              id_valid,
  output logic [7:0]        redirect_count,
  output logic              state_dbg,
  output logic [1:0]        squash_cnt_dbg
);

  typedef enum logic {RUN = 1'b0, SQUASH = 1'b1} state_t;

  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_BEQZ = 4'hD;

  state_t       state, state_n;
  logic [1:0]   cnt, cnt_n;
  logic [3:0]   opcode;
  logic         is_jmp, is_beqz;
  logic [WIDTH-1:0] tgt_jmp, tgt_beqz;
  logic         jump_en;
  logic         drop;

  // Decode the instruction held in IF/ID and form both candidate targets.
  always_comb begin
    opcode   = id_instr[15:12];
    is_jmp   = (opcode == OP_JMP);
    is_beqz  = (opcode == OP_BEQZ);
    tgt_jmp  = id_pc + WIDTH'(1) + {{(WIDTH-12){id_instr[11]}}, id_instr[11:0]};
    tgt_beqz = id_pc + WIDTH'(1) + {{(WIDTH-8){id_instr[7]}}, id_instr[7:0]};
    jump_en  = id_valid & ~stall & (is_jmp | (is_beqz & rs_zero));
    drop     = jump_en | (state == SQUASH);
  end

  assign fetch.jumpEnable  = jump_en;
  assign fetch.jumpAddress = is_jmp ? tgt_jmp : (is_beqz ? tgt_beqz : '0);
  assign state_dbg         = state;
  assign squash_cnt_dbg    = cnt;

  // Squash window sequencing; everything holds while stalled.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (!stall) begin
      case (state)
        RUN: begin
          if (jump_en && (EXTRA_SQUASH > 0)) begin
            state_n = SQUASH;
            cnt_n   = 2'(EXTRA_SQUASH);
          end
        end
        SQUASH: begin
          cnt_n = cnt - 2'd1;
          if (cnt == 2'd1) state_n = RUN;
        end
        default: begin
          state_n = RUN;
          cnt_n   = 2'd0;
        end
      endcase
    end
  end

  // State register for the squash FSM.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      cnt   <= 2'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // IF/ID capture and redirect counter; wrong-path words enter as bubbles.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      id_instr       <= '0;
      id_pc          <= '0;
      id_valid       <= 1'b0;
      redirect_count <= 8'd0;
    end else if (!stall) begin
      id_instr <= fetch.if_instr;
      id_pc    <= fetch.if_pc;
      id_valid <= fetch.if_valid & ~drop;
      if (jump_en) redirect_count <= redirect_count + 8'd1;
    end
  end

endmodule
